// File: rtl/apb_dma_launcher.sv
// APB master sequencer: programs one DMA job, waits for INTR, reads STAT, parks MODE and reports.
// Optional INTR watchdog enabled by defining APB_DMA_LAUNCHER_TIMEOUT_EN.
module apb_dma_launcher #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] SRC_OFS        = 'h00,
  parameter logic [ADDR_W-1:0] DEST_OFS       = 'h04,
  parameter logic [ADDR_W-1:0] SIZE_OFS       = 'h08,
  parameter logic [ADDR_W-1:0] MODE_OFS       = 'h0C,
  parameter logic [ADDR_W-1:0] STAT_OFS       = 'h10,
  parameter logic [ADDR_W-1:0] MSEL_OFS       = 'h14,
  parameter int                TIMEOUT_CYCLES = 4096
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_src_addr,
  input  logic [DATA_W-1:0] cmd_dest_addr,
  input  logic [DATA_W-1:0] cmd_size,
  input  logic [1:0]        cmd_mode,
  input  logic              cmd_mem_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic              rsp_timeout,
  output logic              busy,
  input  logic              INTR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_INTR, RESP} state_t;

  localparam logic [2:0] STEP_SRC  = 3'd0;
  localparam logic [2:0] STEP_MODE = 3'd4;
  localparam logic [2:0] STEP_WAIT = 3'd5;
  localparam logic [2:0] STEP_STAT = 3'd6;
  localparam logic [2:0] STEP_PARK = 3'd7;

  state_t            state_reg, state_next;
  logic [2:0]        step_reg, step_next;
  logic              cmd_ready_reg, cmd_ready_next;
  logic              busy_reg, busy_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [1:0]        rsp_status_reg, rsp_status_next;
  logic              psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic              pwrite_reg, pwrite_next;
  logic [ADDR_W-1:0] paddr_reg, paddr_next;
  logic [DATA_W-1:0] pwdata_reg, pwdata_next;
  logic [DATA_W-1:0] src_reg, dest_reg, size_reg;
  logic [1:0]        mode_reg, stat_reg;
  logic              msel_reg;
  logic              load_job, capture_stat, cmd_reject;
  logic [DATA_W-1:0] src_v;
  logic              timeout_hit, timed_out;

  assign cmd_reject = (cmd_size == '0) || (cmd_mode == 2'b00) || (cmd_mode == 2'b11);
  // The SRC write is set up on the acceptance edge, before the job registers hold the command.
  assign src_v = (state_reg == IDLE) ? cmd_src_addr : src_reg;

  always_comb begin
    state_next      = state_reg;
    step_next       = step_reg;
    cmd_ready_next  = cmd_ready_reg;
    busy_next       = busy_reg;
    rsp_valid_next  = rsp_valid_reg;
    rsp_status_next = rsp_status_reg;
    pwrite_next     = pwrite_reg;
    paddr_next      = paddr_reg;
    pwdata_next     = pwdata_reg;
    load_job        = 1'b0;
    capture_stat    = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready_next = 1'b1;
        if (cmd_valid && cmd_ready_reg) begin
          load_job       = 1'b1;
          busy_next      = 1'b1;
          cmd_ready_next = 1'b0;
          if (cmd_reject) begin
            state_next      = RESP;
            rsp_valid_next  = 1'b1;
            rsp_status_next = 2'b01;
          end else begin
            state_next = SETUP;
            step_next  = STEP_SRC;
          end
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          capture_stat = (step_reg == STEP_STAT);
          case (step_reg)
            STEP_MODE: begin
              state_next = WAIT_INTR;
              step_next  = STEP_WAIT;
            end
            STEP_PARK: begin
              state_next      = RESP;
              rsp_valid_next  = 1'b1;
              rsp_status_next = (!timed_out && stat_reg == 2'b10) ? 2'b10 : 2'b01;
            end
            default: begin
              state_next = SETUP;
              step_next  = step_reg + 3'd1;
            end
          endcase
        end
      end
      WAIT_INTR: begin
        if (INTR) begin
          state_next = SETUP;
          step_next  = STEP_STAT;
        end else if (timeout_hit) begin
          state_next = SETUP;
          step_next  = STEP_PARK;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
          busy_next      = 1'b0;
          cmd_ready_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Address/data are loaded when entering SETUP and held through ACCESS and beyond.
    if (state_next == SETUP) begin
      pwrite_next = 1'b1;
      case (step_next)
        3'd0: begin paddr_next = SRC_OFS;  pwdata_next = src_v; end
        3'd1: begin paddr_next = DEST_OFS; pwdata_next = dest_reg; end
        3'd2: begin paddr_next = SIZE_OFS; pwdata_next = size_reg; end
        3'd3: begin paddr_next = MSEL_OFS; pwdata_next = {{(DATA_W-1){1'b0}}, msel_reg}; end
        3'd4: begin paddr_next = MODE_OFS; pwdata_next = {{(DATA_W-2){1'b0}}, mode_reg}; end
        3'd6: begin paddr_next = STAT_OFS; pwrite_next = 1'b0; end
        default: begin paddr_next = MODE_OFS; pwdata_next = '0; end
      endcase
    end
    psel_next    = (state_next == SETUP) || (state_next == ACCESS);
    penable_next = (state_next == ACCESS);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_reg      <= IDLE;
      step_reg       <= '0;
      cmd_ready_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_status_reg <= 2'b00;
      psel_reg       <= 1'b0;
      penable_reg    <= 1'b0;
      pwrite_reg     <= 1'b0;
      paddr_reg      <= '0;
      pwdata_reg     <= '0;
      src_reg        <= '0;
      dest_reg       <= '0;
      size_reg       <= '0;
      mode_reg       <= 2'b00;
      msel_reg       <= 1'b0;
      stat_reg       <= 2'b00;
    end else begin
      state_reg      <= state_next;
      step_reg       <= step_next;
      cmd_ready_reg  <= cmd_ready_next;
      busy_reg       <= busy_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_status_reg <= rsp_status_next;
      psel_reg       <= psel_next;
      penable_reg    <= penable_next;
      pwrite_reg     <= pwrite_next;
      paddr_reg      <= paddr_next;
      pwdata_reg     <= pwdata_next;
      if (load_job) begin
        src_reg  <= cmd_src_addr;
        dest_reg <= cmd_dest_addr;
        size_reg <= cmd_size;
        mode_reg <= cmd_mode;
        msel_reg <= cmd_mem_sel;
      end
      if (capture_stat) stat_reg <= PRDATA[1:0];
    end
  end

`ifdef APB_DMA_LAUNCHER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_reg;
  logic            timed_out_reg;

  // Count value k means the (k+1)-th WAIT_INTR cycle; INTR has priority over the limit.
  assign timeout_hit = (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));
  assign timed_out   = timed_out_reg;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wd_cnt_reg    <= '0;
      timed_out_reg <= 1'b0;
    end else begin
      wd_cnt_reg <= (state_reg == WAIT_INTR) ? wd_cnt_reg + WD_W'(1) : '0;
      if (state_reg == IDLE) timed_out_reg <= 1'b0;
      else if (state_reg == WAIT_INTR && !INTR && timeout_hit) timed_out_reg <= 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYCLES == 0);
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  logic unused_prdata;
  assign unused_prdata = ^PRDATA[DATA_W-1:2];

  assign cmd_ready   = cmd_ready_reg;
  assign busy        = busy_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_status  = rsp_status_reg;
  assign rsp_timeout = timed_out;
  assign PSEL        = psel_reg;
  assign PENABLE     = penable_reg;
  assign PWRITE      = pwrite_reg;
  assign PADDR       = paddr_reg;
  assign PWDATA      = pwdata_reg;
endmodule

// File: tb/tb_apb_dma_launcher.sv
// Self-checking bench for apb_dma_launcher: vector table, hand-written corner cases and random jobs
// compared against a transaction-level model; APB slave and INTR source are modelled here.
module tb_apb_dma_launcher;
`ifdef APB_DMA_LAUNCHER_TIMEOUT_EN
  localparam int TMO_CYC  = 8;
  localparam int LONG_DLY = 5;
`else
  localparam int TMO_CYC  = 4096;
  localparam int LONG_DLY = 20;
`endif

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_src_addr = '0, cmd_dest_addr = '0, cmd_size = '0;
  logic [1:0]  cmd_mode = 2'b00;
  logic        cmd_mem_sel = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_status;
  logic        rsp_timeout;
  logic        busy;
  logic        INTR = 1'b0;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;

  apb_dma_launcher #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO_CYC)) dut (
    .CLK(CLK), .RSTN(RSTN), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_addr(cmd_src_addr), .cmd_dest_addr(cmd_dest_addr), .cmd_size(cmd_size),
    .cmd_mode(cmd_mode), .cmd_mem_sel(cmd_mem_sel), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_timeout(rsp_timeout), .busy(busy), .INTR(INTR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;

  typedef struct {
    logic [31:0] src, dest, size;
    logic [1:0]  mode;
    logic        msel;
    int          ws;
    logic [1:0]  stat;
    int          intr;     // -1: INTR never rises
    int          rsp_dly;
    logic [1:0]  exp_st;
    logic        exp_to;
  } job_t;

  int    n_pass = 0, n_total = 0;
  int    cyc = 0;
  int    ws = 0, intr_dly = -1, intr_cnt = 0, acc_cnt = 0;
  bit    intr_arm = 1'b0;
  int    clear_gen = 0, clear_seen = 0;
  int    psel_cnt = 0, stab_err = 0;
  xact_t ref_x, cur_x, new_x;
  xact_t log_q[$];
  int    cyc_q[$];
  xact_t exp_q[$];

  logic [1:0] got_st;
  logic       got_to, acc_psel, post_ok;
  int         rsp_lat, hold_err;
  job_t       tbl[9];

  always @(posedge CLK) cyc <= cyc + 1;

  // APB slave with programmable wait states, transfer log and INTR source; acts on the falling edge.
  always @(negedge CLK) begin
    if (clear_gen != clear_seen) begin
      clear_seen = clear_gen;
      log_q.delete();
      cyc_q.delete();
      psel_cnt = 0;
      stab_err = 0;
      intr_arm = 1'b0;
      INTR     = 1'b0;
    end
    if (intr_arm && intr_cnt > 0) begin
      intr_cnt = intr_cnt - 1;
      if (intr_cnt == 0) INTR = 1'b1;
    end
    if (PSEL && PENABLE) acc_cnt = acc_cnt + 1;
    else acc_cnt = 0;
    PREADY = (acc_cnt > ws);
    if (PSEL) psel_cnt = psel_cnt + 1;
    if (PSEL && PENABLE) begin
      cur_x.w = PWRITE; cur_x.addr = PADDR; cur_x.data = PWDATA;
      if (acc_cnt == 1) ref_x = cur_x;
      else if (cur_x != ref_x) stab_err = stab_err + 1;
    end
    if (PSEL && PENABLE && PREADY) begin
      new_x.w = PWRITE; new_x.addr = PADDR; new_x.data = PWRITE ? PWDATA : 32'h0;
      log_q.push_back(new_x);
      cyc_q.push_back(cyc);
      if (PWRITE && PADDR == 32'h0C && PWDATA != 0 && intr_dly >= 0) begin
        intr_arm = 1'b1;
        intr_cnt = intr_dly;
        if (intr_dly == 0) INTR = 1'b1;
      end
      if (!PWRITE && PADDR == 32'h10) begin
        intr_arm = 1'b0;
        INTR     = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic job_t mk(input logic [31:0] src, dest, size, input logic [1:0] mode, input logic msel,
                              input int w, input logic [1:0] stat, input int intr, input int rd,
                              input logic [1:0] est, input logic eto);
    job_t j;
    j.src = src; j.dest = dest; j.size = size; j.mode = mode; j.msel = msel; j.ws = w;
    j.stat = stat; j.intr = intr; j.rsp_dly = rd; j.exp_st = est; j.exp_to = eto;
    return j;
  endfunction

  function automatic bit is_reject(input job_t j);
    return (j.size == 0) || (j.mode == 2'b00) || (j.mode == 2'b11);
  endfunction

  function automatic void push_x(input logic w, input logic [31:0] a, input logic [31:0] d);
    xact_t x;
    x.w = w; x.addr = a; x.data = d;
    exp_q.push_back(x);
  endfunction

  // Reference: the register program a job must produce, and the result it must report.
  function automatic void build_exp(input job_t j);
    exp_q.delete();
    if (is_reject(j)) return;
    push_x(1'b1, 32'h00, j.src);
    push_x(1'b1, 32'h04, j.dest);
    push_x(1'b1, 32'h08, j.size);
    push_x(1'b1, 32'h14, {31'h0, j.msel});
    push_x(1'b1, 32'h0C, {30'h0, j.mode});
    if (j.intr >= 0) push_x(1'b0, 32'h10, 32'h0);
    push_x(1'b1, 32'h0C, 32'h0);
  endfunction

  function automatic logic [2:0] model_result(input job_t j);
    if (is_reject(j)) return {1'b0, 2'b01};
    if (j.intr < 0) return {1'b1, 2'b01};
    return {1'b0, (j.stat == 2'b10) ? 2'b10 : 2'b01};
  endfunction

  task automatic do_reset();
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    tick();
  endtask

  task automatic run_job(input job_t j);
    int n;
    logic [29:0] junk;
    ws       = j.ws;
    intr_dly = j.intr;
    junk     = 30'($urandom());
    PRDATA   = {junk, j.stat};
    clear_gen++;
    cmd_src_addr = j.src; cmd_dest_addr = j.dest; cmd_size = j.size;
    cmd_mode = j.mode; cmd_mem_sel = j.msel; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    if (!cmd_ready) check("cmd_ready_wait", {63'h0, cmd_ready}, 64'h1);
    tick();
    cmd_valid = 1'b0;
    acc_psel  = PSEL && !PENABLE && (PADDR == 32'h00);
    n = 1;
    while (!rsp_valid && n < 3000) begin tick(); n++; end
    rsp_lat = n;
    if (!rsp_valid) begin
      check("rsp_wait", {63'h0, rsp_valid}, 64'h1);
      do_reset();
    end
    got_st   = rsp_status;
    got_to   = rsp_timeout;
    hold_err = 0;
    for (int k = 0; k < j.rsp_dly; k++) begin
      tick();
      if (!rsp_valid || rsp_status != got_st || rsp_timeout != got_to || cmd_ready || !busy)
        hold_err++;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    post_ok = !rsp_valid && !busy && cmd_ready;
  endtask

  task automatic check_job(input string tag, input job_t j, input logic [1:0] est, input logic eto);
    int m;
    build_exp(j);
    check($sformatf("%s.status", tag), {62'h0, got_st}, {62'h0, est});
    check($sformatf("%s.timeout", tag), {63'h0, got_to}, {63'h0, eto});
    check($sformatf("%s.rsp_hold", tag), hold_err, 0);
    check($sformatf("%s.release", tag), {63'h0, post_ok}, 64'h1);
    check($sformatf("%s.xact_count", tag), log_q.size(), exp_q.size());
    m = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s.x%0d.addr", tag, i), {log_q[i].w, log_q[i].addr}, {exp_q[i].w, exp_q[i].addr});
      check($sformatf("%s.x%0d.data", tag, i), log_q[i].data, exp_q[i].data);
    end
    if (is_reject(j)) begin
      check($sformatf("%s.no_psel", tag), psel_cnt, 0);
      check($sformatf("%s.rsp_latency_le2", tag), {63'h0, rsp_lat <= 2}, 64'h1);
    end else begin
      check($sformatf("%s.first_setup", tag), {63'h0, acc_psel}, 64'h1);
      check($sformatf("%s.stable", tag), stab_err, 0);
      if (log_q.size() >= 5)
        check($sformatf("%s.launch_cycles", tag), cyc_q[4] - cyc_q[0], 4 * (2 + j.ws));
    end
    $display("job %s: src=%h dest=%h size=%h mode=%b msel=%b ws=%0d xacts=%0d status=%b timeout=%b",
             tag, j.src, j.dest, j.size, j.mode, j.msel, j.ws, log_q.size(), got_st, got_to);
  endtask

  initial begin
    job_t j;
    logic [2:0] r;
    int n;

    tbl[0] = mk(32'h100, 32'h200, 32'd16, 2'b01, 1'b0, 0, 2'b10, LONG_DLY, 0, 2'b10, 1'b0);
    tbl[1] = mk(32'h100, 32'h200, 32'd16, 2'b01, 1'b0, 3, 2'b10, LONG_DLY, 0, 2'b10, 1'b0);
    tbl[2] = mk(32'h1234, 32'h5678, 32'd64, 2'b01, 1'b1, 0, 2'b01, 3, 5, 2'b01, 1'b0);
    tbl[3] = mk(32'h40, 32'h80, 32'd0, 2'b01, 1'b0, 0, 2'b10, 2, 0, 2'b01, 1'b0);
    tbl[4] = mk(32'h40, 32'h80, 32'd8, 2'b11, 1'b0, 0, 2'b10, 2, 0, 2'b01, 1'b0);
    tbl[5] = mk(32'h40, 32'h80, 32'd8, 2'b00, 1'b1, 0, 2'b10, 2, 1, 2'b01, 1'b0);
    tbl[6] = mk(32'hA000_0000, 32'hB000_0000, 32'hFFFF_FFFF, 2'b10, 1'b1, 1, 2'b10, 0, 2, 2'b10, 1'b0);
    tbl[7] = mk(32'h10, 32'h20, 32'd1, 2'b10, 1'b0, 2, 2'b11, 1, 1, 2'b01, 1'b0);
    tbl[8] = mk(32'h10, 32'h20, 32'd1, 2'b01, 1'b0, 0, 2'b00, 4, 0, 2'b01, 1'b0);

    // Reset state
    tick(); tick(); tick();
    check("rst.cmd_ready", {63'h0, cmd_ready}, 64'h0);
    check("rst.rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check("rst.rsp_status", {62'h0, rsp_status}, 64'h0);
    check("rst.rsp_timeout", {63'h0, rsp_timeout}, 64'h0);
    check("rst.busy", {63'h0, busy}, 64'h0);
    check("rst.apb_ctl", {61'h0, PSEL, PENABLE, PWRITE}, 64'h0);
    check("rst.paddr", PADDR, 64'h0);
    check("rst.pwdata", PWDATA, 64'h0);
    RSTN = 1'b1;
    tick();
    check("rst.cmd_ready_after", {63'h0, cmd_ready}, 64'h1);

    for (int i = 0; i < 9; i++) begin
      run_job(tbl[i]);
      check_job($sformatf("tbl%0d", i), tbl[i], tbl[i].exp_st, tbl[i].exp_to);
    end

    // Reset during ACCESS of the SIZE write, then a fresh job must restart at SRC
    ws = 0; intr_dly = -1; clear_gen++;
    cmd_src_addr = 32'h300; cmd_dest_addr = 32'h400; cmd_size = 32'd4;
    cmd_mode = 2'b01; cmd_mem_sel = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!(PSEL && PENABLE && PADDR == 32'h08) && n < 50) begin tick(); n++; end
    check("midrst.reach_size", {62'h0, PSEL, PENABLE}, 64'h3);
    RSTN = 1'b0;
    tick();
    check("midrst.psel", {63'h0, PSEL}, 64'h0);
    check("midrst.penable", {63'h0, PENABLE}, 64'h0);
    check("midrst.busy", {63'h0, busy}, 64'h0);
    check("midrst.cmd_ready", {63'h0, cmd_ready}, 64'h0);
    RSTN = 1'b1;
    tick();
    check("midrst.cmd_ready_after", {63'h0, cmd_ready}, 64'h1);
    run_job(tbl[0]);
    check_job("midrst.rerun", tbl[0], 2'b10, 1'b0);

`ifdef APB_DMA_LAUNCHER_TIMEOUT_EN
    // INTR never arrives: launch, 8 wait cycles, park MODE, no STAT read
    j = mk(32'h500, 32'h600, 32'd32, 2'b01, 1'b0, 0, 2'b10, -1, 1, 2'b01, 1'b1);
    run_job(j);
    check_job("timeout", j, 2'b01, 1'b1);
    if (log_q.size() >= 6) check("timeout.wait_cycles", cyc_q[5] - cyc_q[4], 10);
    // INTR sampled on the same cycle the limit is reached: normal completion
    j = mk(32'h700, 32'h800, 32'd2, 2'b01, 1'b1, 0, 2'b10, 8, 0, 2'b10, 1'b0);
    run_job(j);
    check_job("tmo_tie", j, 2'b10, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
      j.src  = $urandom();
      j.dest = $urandom();
      j.size = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
      n = $urandom_range(0, 9);
      j.mode = (n == 0) ? 2'b00 : (n == 1) ? 2'b11 : (n < 6) ? 2'b01 : 2'b10;
      j.msel = 1'($urandom_range(0, 1));
      j.ws   = $urandom_range(0, 3);
      j.stat = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      j.intr = $urandom_range(0, 5);
      j.rsp_dly = $urandom_range(0, 3);
      r = model_result(j);
      j.exp_st = r[1:0];
      j.exp_to = r[2];
      run_job(j);
      check_job($sformatf("rnd%0d", i), j, j.exp_st, j.exp_to);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/apb_dma_launcher.md
Name: apb_dma_launcher

Overview:
- APB master sequencer directly upstream of the DMA top's APB slave port.
- Accepts one DMA job at a time on a valid/ready command interface and programs the source, destination, size, memory-select and mode registers over APB.
- Waits for INTR, reads back the status/LED register, returns MODE to idle, and reports the result on a valid/ready response interface.

Parameters:
- ADDR_W, 32, APB address width (matches the DMA top's register address width).
- DATA_W, 32, APB data width and width of command address/size fields.
- SRC_OFS, 32'h00, source address register offset.
- DEST_OFS, 32'h04, destination address register offset.
- SIZE_OFS, 32'h08, transfer size register offset.
- MODE_OFS, 32'h0C, mode register offset (bits[1:0]).
- STAT_OFS, 32'h10, status register offset (LED result in bits[1:0]).
- MSEL_OFS, 32'h14, memory-select register offset (bit0).
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with the optional feature.

Ports:
- CLK  in  1  clock
- RSTN  in  1  synchronous active-low reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  job accepted when high together with cmd_valid
- cmd_src_addr  in  DATA_W  DMA source address
- cmd_dest_addr  in  DATA_W  DMA destination address
- cmd_size  in  DATA_W  transfer size
- cmd_mode  in  2  01 normal, 10 test
- cmd_mem_sel  in  1  0: mem0 is source; 1: mem1 is source
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_status  out  2  10 success, 01 fail, 00 never presented
- rsp_timeout  out  1  result produced by watchdog
- busy  out  1  high from job acceptance to response handshake
- INTR  in  1  DMA done interrupt
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready

Behaviour:
- Reset:
  - One clock and one reset: CLK, synchronous active-low RSTN.
  - RSTN=0 sampled at a CLK edge clears every output: cmd_ready=0, rsp_valid=0, rsp_status=00, rsp_timeout=0, busy=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - FSM returns to IDLE.
  - Reset mid-transfer abandons the APB access; no completion cycle is issued.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch all cmd_* fields and set busy=1 at the next edge.
- Rejection:
  - A job with cmd_size==0, or cmd_mode of 00 or 11, generates no APB traffic.
  - It goes straight to RESP with rsp_status=01.
- FSM states: IDLE, SETUP, ACCESS, WAIT_INTR, RESP.
- Transfer list, in fixed order:
  1. write SRC
  2. write DEST
  3. write SIZE
  4. write MSEL (PWDATA={0, mem_sel})
  5. write MODE (launches the DMA)
  6. wait for INTR
  7. read STAT
  8. write MODE=0
  - A 3-bit step counter indexes the list.
- SETUP: PSEL=1, PENABLE=0; PADDR, PWRITE and PWDATA are valid and held stable through ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; held until PREADY=1.
  - On PREADY, advance the step counter.
  - If another transfer follows immediately, go directly to SETUP with no idle cycle.
  - Otherwise drop PSEL and PENABLE.
  - For the read step, capture PRDATA[1:0] on the PREADY cycle.
- Latency with PREADY tied high:
  - First SETUP is the cycle after acceptance.
  - Each transfer takes 2 cycles, so the 5 writes take 10 cycles.
- WAIT_INTR:
  - No APB activity; leave when INTR=1 is sampled.
  - INTR already high on entry counts immediately.
- Status mapping: captured 10 gives rsp_status=10; any other value gives rsp_status=01.
- RESP:
  - rsp_valid=1 with rsp_status and rsp_timeout stable until rsp_ready.
  - On the handshake, rsp_valid=0, busy=0 and the FSM returns to IDLE.
  - cmd_ready stays 0 until the handshake; the earliest next acceptance is one cycle after the response handshake.
- APB outputs when not in SETUP or ACCESS: PSEL=0, PENABLE=0; PADDR, PWDATA and PWRITE hold their last value.
- A PREADY wait of any length is legal; there is no APB timeout.

Optional Feature:
- Macro: APB_DMA_LAUNCHER_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT_INTR and increments each cycle.
  - If it reaches TIMEOUT_CYCLES with INTR still low, skip the STAT read and perform only the MODE=0 write.
  - Then respond with rsp_status=01 and rsp_timeout=1.
  - INTR and the limit reached in the same cycle: INTR wins (normal path).
- When undefined:
  - WAIT_INTR waits indefinitely; rsp_timeout is tied to 0 and no counter is built.

Test Plan:
1. Normal job: PREADY=1; src=0x100, dest=0x200, size=16, mode=01, mem_sel=0; INTR asserted 20 cycles after MODE write; STAT reads 0x2. Required: writes 0x00=0x100, 0x04=0x200, 0x08=16, 0x14=0, 0x0C=1, then read 0x10, then write 0x0C=0; rsp_status=10, rsp_timeout=0; first PSEL in cycle after acceptance.
2. Wait states: PREADY low 3 cycles on every access. Required: each access holds PSEL=1, PENABLE=1 and stable PADDR/PWDATA for 4 cycles; same write sequence and result as test 1.
3. Fail and backpressure: STAT reads 0x1 with mem_sel=1; rsp_ready held low 5 cycles. Required: MSEL write data 1; rsp_status=01 held for 5 cycles; cmd_ready=0 until the handshake.
4. Rejection: cmd_size=0, mode=01; then a separate job with mode=11. Required: no PSEL; rsp_valid within 2 cycles; rsp_status=01 for both.
5. Reset mid-operation: RSTN=0 for one edge during ACCESS of the SIZE write. Required: next cycle PSEL=0, PENABLE=0, busy=0, cmd_ready=0; cmd_ready=1 after RSTN returns high; a new job restarts from the SRC write.
6. With APB_DMA_LAUNCHER_TIMEOUT_EN and TIMEOUT_CYCLES=8: INTR never asserted. Required: after the MODE launch write and 8 WAIT_INTR cycles, write 0x0C=0 with no read of 0x10; rsp_status=01, rsp_timeout=1.
